// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } arb_owner_t;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the shared memory port: data first, fetch forced after
// STARVE_MAX consecutive data grants taken while fetch was waiting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       imem_req,
  input  logic       dmem_req,
  input  logic       imem_gnt,
  input  logic       dmem_gnt,
  output arb_owner_t winner,
  output logic       forced_win
);

  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_reg;

  assign forced_win = imem_req && (starve_reg == STARVE_LIM);

  always_comb begin
    if (forced_win)    winner = OWN_IMEM;
    else if (dmem_req) winner = OWN_DMEM;
    else if (imem_req) winner = OWN_IMEM;
    else               winner = OWN_NONE;
  end

  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_reg <= '0;
    end else if (imem_gnt) begin
      starve_reg <= '0;
    end else if (dmem_gnt && imem_req && (starve_reg != STARVE_LIM)) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and MEM stage, one transaction
// in flight. Define MEM_ARB_PERF_EN for live conflict/starvation counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_req_i,
  input  logic [ADDR_W-1:0]     imem_addr_i,
  output logic                  imem_gnt_o,
  output logic                  imem_rvalid_o,
  output logic [DATA_W-1:0]     imem_rdata_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_W-1:0]     dmem_addr_i,
  input  logic [DATA_W-1:0]     dmem_wdata_i,
  input  logic [DATA_W/8-1:0]   dmem_wstrb_i,
  output logic                  dmem_gnt_o,
  output logic                  dmem_rvalid_o,
  output logic [DATA_W-1:0]     dmem_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wstrb_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic [PERF_CNT_W-1:0] conflict_cnt_o,
  output logic [PERF_CNT_W-1:0] starve_cnt_o
);

  arb_state_t state_reg, state_next;
  arb_owner_t owner_reg, owner_next;
  arb_owner_t winner, cur_owner;
  logic       forced_win, any_req, req_active, sel_imem, sel_dmem, rsp_fire;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req_i),
    .dmem_req   (dmem_req_i),
    .imem_gnt   (imem_gnt_o),
    .dmem_gnt   (dmem_gnt_o),
    .winner     (winner),
    .forced_win (forced_win)
  );

  // In IDLE the fresh winner drives the port; afterwards the owner is locked.
  assign any_req    = imem_req_i | dmem_req_i;
  assign cur_owner  = (state_reg == ARB_IDLE) ? winner : owner_reg;
  assign req_active = (state_reg == ARB_REQ) || ((state_reg == ARB_IDLE) && any_req);
  assign sel_imem   = req_active && (cur_owner == OWN_IMEM);
  assign sel_dmem   = req_active && (cur_owner == OWN_DMEM);
  assign rsp_fire   = (state_reg == ARB_RSP) && mem_rvalid_i;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (any_req) begin
          owner_next = winner;
          if (mem_gnt_i) state_next = ARB_RSP;
          else           state_next = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_gnt_i) state_next = ARB_RSP;
      end
      ARB_RSP: begin
        if (mem_rvalid_i) begin
          state_next = ARB_IDLE;
          owner_next = OWN_NONE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ARB_IDLE;
      owner_reg <= OWN_NONE;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  assign mem_req_o   = req_active;
  assign mem_we_o    = sel_dmem && dmem_we_i;
  assign mem_addr_o  = sel_dmem ? dmem_addr_i : (sel_imem ? imem_addr_i : '0);
  assign mem_wdata_o = mem_we_o ? dmem_wdata_i : '0;
  assign mem_wstrb_o = mem_we_o ? dmem_wstrb_i : '0;

  assign imem_gnt_o    = sel_imem && mem_gnt_i;
  assign dmem_gnt_o    = sel_dmem && mem_gnt_i;
  assign imem_rvalid_o = rsp_fire && (owner_reg == OWN_IMEM);
  assign dmem_rvalid_o = rsp_fire && (owner_reg == OWN_DMEM);
  assign imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
  assign dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] conflict_cnt_reg, starve_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt_reg <= '0;
      starve_cnt_reg   <= '0;
    end else begin
      if ((state_reg != ARB_RSP) && imem_req_i && dmem_req_i)
        conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
      if ((state_reg == ARB_IDLE) && forced_win)
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_reg;
  assign starve_cnt_o   = starve_cnt_reg;
`else
  logic perf_unused;
  assign perf_unused    = forced_win;
  assign conflict_cnt_o = '0;
  assign starve_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus queues expected
// grant/response pulses, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

`ifdef MEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] K_IG = 4'b1000;
  localparam logic [3:0] K_DG = 4'b0100;
  localparam logic [3:0] K_IR = 4'b0010;
  localparam logic [3:0] K_DR = 4'b0001;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req_i, imem_gnt_o, imem_rvalid_o;
  logic [ADDR_W-1:0] imem_addr_i;
  logic [DATA_W-1:0] imem_rdata_o;
  logic              dmem_req_i, dmem_we_i, dmem_gnt_o, dmem_rvalid_o;
  logic [ADDR_W-1:0] dmem_addr_i;
  logic [DATA_W-1:0] dmem_wdata_i, dmem_rdata_o;
  logic [STRB_W-1:0] dmem_wstrb_i;
  logic              mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
  logic [STRB_W-1:0] mem_wstrb_o;
  logic [31:0]       conflict_cnt_o, starve_cnt_o;

  logic              gnt_en;
  assign mem_gnt_i = mem_req_o & gnt_en;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_i     (imem_req_i),
    .imem_addr_i    (imem_addr_i),
    .imem_gnt_o     (imem_gnt_o),
    .imem_rvalid_o  (imem_rvalid_o),
    .imem_rdata_o   (imem_rdata_o),
    .dmem_req_i     (dmem_req_i),
    .dmem_we_i      (dmem_we_i),
    .dmem_addr_i    (dmem_addr_i),
    .dmem_wdata_i   (dmem_wdata_i),
    .dmem_wstrb_i   (dmem_wstrb_i),
    .dmem_gnt_o     (dmem_gnt_o),
    .dmem_rvalid_o  (dmem_rvalid_o),
    .dmem_rdata_o   (dmem_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wstrb_o    (mem_wstrb_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .conflict_cnt_o (conflict_cnt_o),
    .starve_cnt_o   (starve_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  kind;
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic        rsp_pend;
  int          rsp_cnt, rsp_delay;
  logic [31:0] rsp_data;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic void expect_ev(input logic [3:0] kind, input int c, input logic [31:0] addr,
                                    input logic we, input logic [31:0] wdata,
                                    input logic [3:0] wstrb, input logic [31:0] rdata);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = addr; e.we = we;
    e.wdata = wdata; e.wstrb = wstrb; e.rdata = rdata;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] rd_val(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEADBEEF : (addr ^ 32'h5A5A_0000);
  endfunction

  // One clock of requester + memory behaviour; returns 1 time unit after the edge.
  task automatic step();
    logic ig, dg;
    @(negedge clk);
    ig = imem_gnt_o;
    dg = dmem_gnt_o;
    if (mem_req_o && mem_gnt_i) begin
      rsp_pend = 1'b1;
      rsp_cnt  = rsp_delay;
      rsp_data = mem_we_o ? 32'h0 : rd_val(mem_addr_o);
    end
    @(posedge clk);
    #1;
    if (ig) imem_req_i = 1'b0;
    if (dg) dmem_req_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (rsp_pend) begin
      if (rsp_cnt <= 1) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rsp_data;
        rsp_pend     = 1'b0;
      end else begin
        rsp_cnt--;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] pulses;
    exp_t       e;
    pulses = {imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o};
    if (pulses != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {28'h0, pulses}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        $display("txn cycle %0d pulses=%b expected=%b", cyc, pulses, e.kind);
        chk("pulse_kind", {28'h0, pulses}, {28'h0, e.kind});
        chk("pulse_cycle", cyc, e.cyc);
        if (e.kind[3] || e.kind[2]) begin
          chk("mem_addr", mem_addr_o, e.addr);
          chk("mem_we", {31'h0, mem_we_o}, {31'h0, e.we});
          chk("mem_wstrb", {28'h0, mem_wstrb_o}, {28'h0, e.wstrb});
          if (e.we) chk("mem_wdata", mem_wdata_o, e.wdata);
        end else begin
          chk("imem_rdata", imem_rdata_o, e.kind[1] ? e.rdata : 32'h0);
          chk("dmem_rdata", dmem_rdata_o, e.kind[0] ? e.rdata : 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    reset = 1'b0; gnt_en = 1'b1; rsp_delay = 1; rsp_pend = 1'b0; rsp_cnt = 0; rsp_data = '0;
    imem_req_i = 1'b0; imem_addr_i = '0;
    dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0; dmem_wstrb_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_gnts", {30'h0, imem_gnt_o, dmem_gnt_o}, 32'h0);
    chk("rst_rvalids", {30'h0, imem_rvalid_o, dmem_rvalid_o}, 32'h0);
    chk("rst_conflict", conflict_cnt_o, 32'h0);
    chk("rst_starve", starve_cnt_o, 32'h0);
    reset = 1'b1;
    step();
    chk("idle_mem_req", {31'h0, mem_req_o}, 32'h0);

    // Fetch-only read, zero-wait grant
    c = cyc;
    imem_req_i = 1'b1; imem_addr_i = 32'h100;
    expect_ev(K_IG, c,     32'h100, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_IR, c + 1, 32'h0,   1'b0, 32'h0, 4'h0, 32'hDEADBEEF);
    repeat (3) step();
    chk("t1_conflict", conflict_cnt_o, 32'h0);

    // Simultaneous store and fetch: data first
    c = cyc;
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h200;
    dmem_wdata_i = 32'hCAFE0000; dmem_wstrb_i = 4'hF;
    imem_req_i = 1'b1; imem_addr_i = 32'h104;
    expect_ev(K_DG, c,     32'h200, 1'b1, 32'hCAFE0000, 4'hF, 32'h0);
    expect_ev(K_DR, c + 1, 32'h0,   1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_IG, c + 2, 32'h104, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_IR, c + 3, 32'h0,   1'b0, 32'h0, 4'h0, 32'h5A5A0104);
    repeat (5) step();
    dmem_we_i = 1'b0; dmem_wdata_i = '0; dmem_wstrb_i = '0;
    chk("t2_conflict", conflict_cnt_o, PERF ? 32'd1 : 32'd0);

    // Starvation: four data wins, then fetch is forced
    c = cyc;
    imem_req_i = 1'b1; imem_addr_i = 32'h108;
    dmem_req_i = 1'b1; dmem_addr_i = 32'h300;
    for (int k = 0; k < 4; k++) begin
      expect_ev(K_DG, c + 2*k,     32'h300 + 32'(4*k), 1'b0, 32'h0, 4'h0, 32'h0);
      expect_ev(K_DR, c + 2*k + 1, 32'h0, 1'b0, 32'h0, 4'h0, rd_val(32'h300 + 32'(4*k)));
    end
    expect_ev(K_IG, c + 8,  32'h108, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_IR, c + 9,  32'h0,   1'b0, 32'h0, 4'h0, 32'h5A5A0108);
    expect_ev(K_DG, c + 10, 32'h310, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_DR, c + 11, 32'h0,   1'b0, 32'h0, 4'h0, 32'h5A5A0310);
    for (int k = 0; k < 4; k++) begin
      step();
      dmem_req_i = 1'b1; dmem_addr_i = 32'h300 + 32'(4*(k+1));
      step();
    end
    repeat (5) step();
    chk("t3_starve", starve_cnt_o, PERF ? 32'd1 : 32'd0);
    chk("t3_conflict", conflict_cnt_o, PERF ? 32'd6 : 32'd0);

    // Locked owner while memory stalls; data request arrives mid-wait
    c = cyc;
    gnt_en = 1'b0;
    imem_req_i = 1'b1; imem_addr_i = 32'h400;
    expect_ev(K_IG, c + 3, 32'h400, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_IR, c + 4, 32'h0,   1'b0, 32'h0, 4'h0, 32'h5A5A0400);
    expect_ev(K_DG, c + 5, 32'h500, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_DR, c + 6, 32'h0,   1'b0, 32'h0, 4'h0, 32'h5A5A0500);
    #1;
    chk("t4_req_c0", {31'h0, mem_req_o}, 32'h1);
    chk("t4_addr_c0", mem_addr_o, 32'h400);
    step();
    dmem_req_i = 1'b1; dmem_addr_i = 32'h500;
    #1;
    chk("t4_addr_c1", mem_addr_o, 32'h400);
    step();
    #1;
    chk("t4_addr_c2", mem_addr_o, 32'h400);
    step();
    gnt_en = 1'b1;
    #1;
    chk("t4_addr_c3", mem_addr_o, 32'h400);
    repeat (5) step();
    chk("t4_conflict", conflict_cnt_o, PERF ? 32'd9 : 32'd0);

    // Reset while waiting for the response; stale response must be dropped
    c = cyc;
    rsp_delay = 3;
    imem_req_i = 1'b1; imem_addr_i = 32'h600;
    expect_ev(K_IG, c, 32'h600, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("t5_rst_conflict", conflict_cnt_o, 32'h0);
    chk("t5_rst_starve", starve_cnt_o, 32'h0);
    step();
    reset = 1'b1;
    step();
    #1;
    chk("t5_stale_seen", {31'h0, mem_rvalid_i}, 32'h1);
    chk("t5_no_rvalid", {30'h0, imem_rvalid_o, dmem_rvalid_o}, 32'h0);
    chk("t5_idle_req", {31'h0, mem_req_o}, 32'h0);
    step();
    chk("t5_conflict", conflict_cnt_o, 32'h0);
    chk("t5_starve", starve_cnt_o, 32'h0);

    // Fresh fetch after the abandoned transaction
    rsp_delay = 1;
    c = cyc;
    imem_req_i = 1'b1; imem_addr_i = 32'h100;
    expect_ev(K_IG, c,     32'h100, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ev(K_IR, c + 1, 32'h0,   1'b0, 32'h0, 4'h0, 32'hDEADBEEF);
    repeat (4) step();

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
